// File: rtl/ks_pkg.sv
// Shared encodings for the K&S 16-bit processor control unit and datapath.
package ks_pkg;

  localparam int unsigned INSTR_W  = 5;
  localparam int unsigned ALU_OP_W = 2;
  localparam int unsigned STATE_W  = 4;

  typedef enum logic [INSTR_W-1:0] {
    I_NOP    = 5'd0,
    I_LOAD   = 5'd1,
    I_STORE  = 5'd2,
    I_MOVE   = 5'd3,
    I_ADD    = 5'd4,
    I_SUB    = 5'd5,
    I_AND    = 5'd6,
    I_OR     = 5'd7,
    I_BRANCH = 5'd8,
    I_BZERO  = 5'd9,
    I_BNZERO = 5'd10,
    I_BNEG   = 5'd11,
    I_BNNEG  = 5'd12,
    I_BOV    = 5'd13,
    I_BNOV   = 5'd14,
    I_BUOV   = 5'd15,
    I_BNUOV  = 5'd16,
    I_HALT   = 5'd31
  } decoded_instruction_e;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } alu_op_e;

  typedef enum logic [STATE_W-1:0] {
    RST_IDLE = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    LOAD     = 4'd3,
    STORE    = 4'd4,
    MOVE     = 4'd5,
    ALU      = 4'd6,
    BRANCH   = 4'd7,
    HALT     = 4'd8
  } ctrl_state_e;

  // ALU operation implied by an arithmetic/logic instruction class
  function automatic alu_op_e alu_op_of(input logic [INSTR_W-1:0] instr);
    alu_op_e op;
    case (instr)
      I_SUB:   op = OP_SUB;
      I_AND:   op = OP_AND;
      I_OR:    op = OP_OR;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/control_unit_branch_cond.sv
// Branch-taken decision from the instruction class and the current ALU flags.
module branch_cond
  import ks_pkg::*;
(
  input  logic [INSTR_W-1:0] decoded_instruction,
  input  logic               zero,
  input  logic               neg,
  input  logic               unsigned_overflow,
  input  logic               signed_overflow,
  output logic               take_branch
);

  // Unconditional branch always taken; conditional ones test a single flag
  always_comb begin
    take_branch = 1'b0;
    case (decoded_instruction)
      I_BRANCH: take_branch = 1'b1;
      I_BZERO:  take_branch = zero;
      I_BNZERO: take_branch = ~zero;
      I_BNEG:   take_branch = neg;
      I_BNNEG:  take_branch = ~neg;
      I_BOV:    take_branch = signed_overflow;
      I_BNOV:   take_branch = ~signed_overflow;
      I_BUOV:   take_branch = unsigned_overflow;
      I_BNUOV:  take_branch = ~unsigned_overflow;
      default:  take_branch = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle Moore controller sequencing FETCH -> DECODE -> EXECUTE.
module control_unit
  import ks_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [INSTR_W-1:0]  decoded_instruction,
  input  logic                zero,
  input  logic                neg,
  input  logic                unsigned_overflow,
  input  logic                signed_overflow,
  output logic                branch,
  output logic                pc_enable,
  output logic                ir_enable,
  output logic                addr_sel,
  output logic                c_sel,
  output logic                write_reg_enable,
  output logic [ALU_OP_W-1:0] operation,
  output logic                ram_write_enable,
  output logic                halted
);

  ctrl_state_e state_q, state_d;
  alu_op_e     op_q, op_d;
  logic        take_branch;

  branch_cond u_branch_cond (
    .decoded_instruction (decoded_instruction),
    .zero                (zero),
    .neg                 (neg),
    .unsigned_overflow   (unsigned_overflow),
    .signed_overflow     (signed_overflow),
    .take_branch         (take_branch)
  );

  // State register; the ALU op is captured in DECODE so ALU outputs depend on state only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_IDLE;
      op_q    <= OP_ADD;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic; flags and instruction only matter in DECODE
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      RST_IDLE: state_d = FETCH;
      FETCH:    state_d = DECODE;
      DECODE: begin
        case (decoded_instruction)
          I_LOAD:  state_d = LOAD;
          I_STORE: state_d = STORE;
          I_MOVE:  state_d = MOVE;
          I_ADD, I_SUB, I_AND, I_OR: begin
            state_d = ALU;
            op_d    = alu_op_of(decoded_instruction);
          end
          I_HALT:  state_d = HALT;
          default: state_d = take_branch ? BRANCH : FETCH;
        endcase
      end
      LOAD, STORE, MOVE, ALU, BRANCH: state_d = FETCH;
      HALT:     state_d = HALT;
      default:  state_d = FETCH;
    endcase
  end

  // Output decode from the state register
  always_comb begin
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    write_reg_enable = 1'b0;
    operation        = OP_ADD;
    ram_write_enable = 1'b0;
    halted           = 1'b0;
    case (state_q)
      FETCH:  ir_enable = 1'b1;
      DECODE: pc_enable = 1'b1;
      LOAD: begin
        addr_sel         = 1'b1;
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
      end
      STORE: begin
        addr_sel         = 1'b1;
        ram_write_enable = 1'b1;
      end
      MOVE: begin
        write_reg_enable = 1'b1;
        operation        = OP_OR;
      end
      ALU: begin
        write_reg_enable = 1'b1;
        operation        = op_q;
      end
      BRANCH: begin
        pc_enable = 1'b1;
        branch    = 1'b1;
      end
      HALT:   halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction expected cycle vectors.
module tb_control_unit;
  import ks_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] instr = 5'd0;
  logic       zero = 1'b0, neg = 1'b0, uov = 1'b0, sov = 1'b0;
  logic       branch, pc_enable, ir_enable, addr_sel, c_sel, write_reg_enable;
  logic [1:0] operation;
  logic       ram_write_enable, halted;

  control_unit dut (
    .clk                 (clk),
    .rst                 (rst),
    .decoded_instruction (instr),
    .zero                (zero),
    .neg                 (neg),
    .unsigned_overflow   (uov),
    .signed_overflow     (sov),
    .branch              (branch),
    .pc_enable           (pc_enable),
    .ir_enable           (ir_enable),
    .addr_sel            (addr_sel),
    .c_sel               (c_sel),
    .write_reg_enable    (write_reg_enable),
    .operation           (operation),
    .ram_write_enable    (ram_write_enable),
    .halted              (halted)
  );

  always #5 clk = ~clk;

  // {branch, pc_en, ir_en, addr_sel, c_sel, wr_en, op[1:0], ram_we, halted}
  typedef logic [9:0] outs_t;
  typedef struct {
    outs_t v;
    string tag;
  } exp_t;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  outs_t act;

  assign act = {branch, pc_enable, ir_enable, addr_sel, c_sel, write_reg_enable,
                operation, ram_write_enable, halted};

  function automatic outs_t mk(input logic br, input logic pc, input logic ir,
                               input logic as, input logic cs, input logic we,
                               input logic [1:0] op, input logic rwe, input logic h);
    return {br, pc, ir, as, cs, we, op, rwe, h};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic push(input outs_t v, input string tag);
    exp_t e;
    e.v   = v;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // flags packed as {zero, neg, unsigned_overflow, signed_overflow}
  function automatic logic taken(input logic [4:0] c, input logic [3:0] f);
    case (c)
      5'd8:    return 1'b1;
      5'd9:    return f[3];
      5'd10:   return ~f[3];
      5'd11:   return f[2];
      5'd12:   return ~f[2];
      5'd13:   return f[0];
      5'd14:   return ~f[0];
      5'd15:   return f[1];
      5'd16:   return ~f[1];
      default: return 1'b0;
    endcase
  endfunction

  function automatic int model_len(input logic [4:0] c, input logic [3:0] f);
    if (c >= 5'd1 && c <= 5'd7) return 3;
    if (taken(c, f)) return 3;
    return 2;
  endfunction

  // One-vector-per-cycle comparison against the queued expectations
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, 32'(act), 32'(e.v));
    end
    check("inv_wr_ramwe", 32'(write_reg_enable & ram_write_enable), 32'd0);
    check("inv_ir_pc", 32'(ir_enable & pc_enable), 32'd0);
  end

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      push(10'd0, "reset");
      @(posedge clk); #1;
    end
    rst = 1'b0;
    push(10'd0, "rst_idle");
    @(posedge clk); #1;
  endtask

  // Drives one instruction; flags are inverted outside DECODE to show they are ignored there
  task automatic run_instr(input logic [4:0] c, input logic [3:0] f, input string tag);
    int    n = model_len(c, f);
    outs_t ev;
    instr = c;
    {zero, neg, uov, sov} = ~f;
    push(mk(0, 0, 1, 0, 0, 0, 2'd0, 0, 0), {tag, "_fetch"});
    push(mk(0, 1, 0, 0, 0, 0, 2'd0, 0, 0), {tag, "_decode"});
    if (n == 3) begin
      case (c)
        5'd1:                     ev = mk(0, 0, 0, 1, 1, 1, 2'd0, 0, 0);
        5'd2:                     ev = mk(0, 0, 0, 1, 0, 0, 2'd0, 1, 0);
        5'd3:                     ev = mk(0, 0, 0, 0, 0, 1, 2'd3, 0, 0);
        5'd4, 5'd5, 5'd6, 5'd7:   ev = mk(0, 0, 0, 0, 0, 1, 2'(c - 5'd4), 0, 0);
        default:                  ev = mk(1, 1, 0, 0, 0, 0, 2'd0, 0, 0);
      endcase
      push(ev, {tag, "_exec"});
    end
    @(posedge clk); #1;
    {zero, neg, uov, sov} = f;
    @(posedge clk); #1;
    {zero, neg, uov, sov} = ~f;
    if (n == 3) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset(3);

    run_instr(5'd0, 4'b0000, "nop0");
    run_instr(5'd0, 4'b1010, "nop1");
    run_instr(5'd0, 4'b0101, "nop2");
    run_instr(I_ADD, 4'b0000, "add");
    run_instr(I_SUB, 4'b1111, "sub");
    run_instr(I_AND, 4'b0110, "and");
    run_instr(I_OR, 4'b1001, "or");
    run_instr(I_MOVE, 4'b0011, "move");
    run_instr(I_LOAD, 4'b0000, "load");
    run_instr(I_STORE, 4'b0000, "store");
    run_instr(I_BRANCH, 4'b0000, "branch");

    for (int c = 9; c <= 16; c++) begin
      for (int tk = 0; tk < 2; tk++) begin
        int         idx;
        logic [3:0] f;
        idx = (c <= 10) ? 3 : (c <= 12) ? 2 : (c <= 14) ? 0 : 1;
        f = 4'($urandom);
        f[idx] = (c % 2 == 1) ? tk[0] : ~tk[0];
        run_instr(5'(c), f, $sformatf("cond%0d_t%0d", c, tk));
      end
    end

    run_instr(5'd20, 4'b1111, "illegal20");

    // HALT: held for 20 cycles, only rst leaves it
    instr = I_HALT;
    push(mk(0, 0, 1, 0, 0, 0, 2'd0, 0, 0), "halt_fetch");
    push(mk(0, 1, 0, 0, 0, 0, 2'd0, 0, 0), "halt_decode");
    repeat (20) push(mk(0, 0, 0, 0, 0, 0, 2'd0, 0, 1), "halt_hold");
    repeat (22) begin
      @(posedge clk); #1;
    end
    check("halt_lit_halted", 32'(halted), 32'd1);
    check("halt_lit_pc", 32'(pc_enable), 32'd0);
    do_reset(2);
    run_instr(5'd0, 4'b0000, "post_halt_nop");

    // Asynchronous reset in the middle of LOAD
    instr = I_LOAD;
    push(mk(0, 0, 1, 0, 0, 0, 2'd0, 0, 0), "mid_fetch");
    push(mk(0, 1, 0, 0, 0, 0, 2'd0, 0, 0), "mid_decode");
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_load_wr", 32'(write_reg_enable), 32'd1);
    check("mid_load_addr", 32'(addr_sel), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_wr", 32'(write_reg_enable), 32'd0);
    push(10'd0, "mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    push(10'd0, "mid_rst_idle");
    @(posedge clk); #1;
    run_instr(I_ADD, 4'b0000, "post_rst_add");

    check("model_len_nop", 32'(model_len(I_NOP, 4'b0000)), 32'd2);
    check("model_len_bzero_t", 32'(model_len(I_BZERO, 4'b1000)), 32'd3);
    check("model_len_bzero_f", 32'(model_len(I_BZERO, 4'b0111)), 32'd2);
    check("model_len_bnuov_t", 32'(model_len(I_BNUOV, 4'b0000)), 32'd3);
    check("model_len_load", 32'(model_len(I_LOAD, 4'b0000)), 32'd3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle FSM controller for the K&S 16-bit processor.
- It is the counterpart of the datapath.
  - Consumes the datapath's decoded instruction and ALU flags.
  - Drives the datapath's enables, selects and ALU operation.
  - Drives the RAM write strobe.
- Sits beside the datapath in the top-level CPU. Sequences FETCH → DECODE → EXECUTE for every instruction.

Parameters:
None. Encodings are fixed in the shared package.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock, asynchronous, active-high
- decoded_instruction  in  5  instruction class from the datapath IR decoder (package enum)
- zero  in  1  datapath zero flag
- neg  in  1  datapath negative flag
- unsigned_overflow  in  1  datapath carry-out flag
- signed_overflow  in  1  datapath two's-complement overflow flag
- branch  out  1  1: PC loads IR address field on pc_enable; 0: PC+1
- pc_enable  out  1  PC register write enable
- ir_enable  out  1  IR loads data_in
- addr_sel  out  1  0: RAM address = PC; 1: RAM address = IR address field
- c_sel  out  1  register write source; 0: ALU result, 1: RAM data_in
- write_reg_enable  out  1  register-file write enable; datapath also latches flags when c_sel=0
- operation  out  2  ALU op (package alu_op_e)
- ram_write_enable  out  1  RAM write strobe, data = datapath data_out
- halted  out  1  high while in HALT

Behaviour:
- RAM model: asynchronous read (data_in valid in the same cycle as addr), synchronous write.
- Moore FSM. All outputs decode combinationally from the state register only. Next state depends on the state, decoded_instruction and the flags.
- Unlisted outputs are 0 in each state. operation defaults to OP_ADD.
- Reset:
  - rst high forces state RST_IDLE asynchronously, from any state, mid-instruction included.
  - RST_IDLE drives all outputs 0 and halted 0.
  - First rising edge after rst falls: RST_IDLE → FETCH.
- States and outputs:
  - FETCH: addr_sel=0, ir_enable=1. → DECODE.
  - DECODE: pc_enable=1, branch=0 (PC+1). Next state:
    - LOAD → LOAD
    - STORE → STORE
    - MOVE → MOVE
    - ADD/SUB/AND/OR → ALU
    - BRANCH, or conditional branch with condition true → BRANCH
    - conditional branch false → FETCH
    - HALT → HALT
    - NOP and any unlisted code → FETCH
  - LOAD: addr_sel=1, c_sel=1, write_reg_enable=1. → FETCH.
  - STORE: addr_sel=1, ram_write_enable=1. → FETCH.
  - MOVE: c_sel=0, write_reg_enable=1, operation=OP_OR. The datapath routes the source register to both ALU operands. → FETCH.
  - ALU: c_sel=0, write_reg_enable=1, operation from the instruction (ADD→OP_ADD, SUB→OP_SUB, AND→OP_AND, OR→OP_OR). → FETCH.
  - BRANCH: pc_enable=1, branch=1. → FETCH.
  - HALT: halted=1, all enables 0. Exits only via rst.
- Branch conditions:
  - Evaluated in DECODE on the flag values present that cycle, i.e. the flags of the last ALU/MOVE instruction.
  - BZERO: zero=1; BNZERO: zero=0.
  - BNEG: neg=1; BNNEG: neg=0.
  - BOV: signed_overflow=1; BNOV: signed_overflow=0.
  - BUOV: unsigned_overflow=1; BNUOV: unsigned_overflow=0.
- Latency in cycles, FETCH to next FETCH:
  - NOP and branch-not-taken: 2.
  - LOAD, STORE, MOVE, ALU and branch-taken: 3.
- Invariants, never asserted together:
  - write_reg_enable with ram_write_enable.
  - ir_enable with pc_enable.
- Flags changing outside DECODE have no effect.
- Illegal state-register values recover to FETCH on the next edge.

Decomposition:
- Package ks_pkg:
  - decoded_instruction_e (5 bit): I_NOP=0, I_LOAD=1, I_STORE=2, I_MOVE=3, I_ADD=4, I_SUB=5, I_AND=6, I_OR=7, I_BRANCH=8, I_BZERO=9, I_BNZERO=10, I_BNEG=11, I_BNNEG=12, I_BOV=13, I_BNOV=14, I_BUOV=15, I_BNUOV=16, I_HALT=31.
  - alu_op_e (2 bit): OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3.
  - ctrl_state_e: RST_IDLE, FETCH, DECODE, LOAD, STORE, MOVE, ALU, BRANCH, HALT.
  - The datapath shares the same package.
- One sub-module: branch_cond, combinational. Inputs are decoded_instruction and the four flags. Output is take_branch.

Test Plan:
- Reset then NOP stream: rst high 3 cycles, release, decoded_instruction=I_NOP → all outputs 0 during reset; first cycle after release is RST_IDLE (all 0); then ir_enable pulses every 2 cycles; pc_enable in alternate cycles; write_reg_enable and ram_write_enable never 1.
- I_ADD then I_SUB → DECODE, then ALU with write_reg_enable=1, c_sel=0, operation=0; next instruction's ALU state has operation=1; 3 cycles each.
- I_LOAD then I_STORE:
  - LOAD state: addr_sel=1, c_sel=1, write_reg_enable=1.
  - STORE state: addr_sel=1, ram_write_enable=1, write_reg_enable=0.
- Branch conditions:
  - I_BZERO with zero=1 → BRANCH state with pc_enable=1, branch=1, 3-cycle instruction.
  - I_BZERO with zero=0 → DECODE→FETCH, 2 cycles.
  - Repeat both cases for each of the 8 conditional codes.
- I_HALT → halted=1 held for 20 cycles, all enables 0; rst pulse → halted=0, FETCH resumes.
- Reset mid-instruction: rst asserted asynchronously between edges during LOAD → write_reg_enable drops to 0 before the next edge; restart at RST_IDLE. Illegal decode code 5'd20 → treated as NOP, 2 cycles.
